spart: RTL and testbench
========================

// Module: spart
// PURPOSE
//  Special-purpose async receiver/transmitter: 8N1 UART with a processor-side bus.
//  Bus side: iocs, iorw, 2-bit ioaddr and a shared bidirectional 8-bit databus.
//  Line side: txd/rxd serial pins. Two instances cross-connected (txd->rxd) form a loopback link.
//  Baud rate is set by a 16-bit divisor written through the bus (0x00A2 = 9600 baud @ 25 MHz).
// PARAMETERS
//  DEFAULT_DIVISOR  16'h00A2  divisor value loaded at reset
//  OVERSAMPLE       16        baud ticks per serial bit (localparam, not overridable)
// PORTS
//  clk      in     1  system clock, all logic posedge
//  rst      in     1  reset, asynchronous, active-low
//  iocs     in     1  chip select; bus access only when 1
//  iorw     in     1  1 = read (DUT drives databus), 0 = write (DUT samples databus)
//  rda      out    1  receive data available
//  tbr      out    1  transmit buffer ready
//  ioaddr   in     2  00 TX/RX data, 01 status, 10 divisor low, 11 divisor high
//  databus  inout  8  shared data bus, tri-stated when not driven
//  txd      out    1  serial out, idles high
//  rxd      in     1  serial in, asynchronous to clk
// BEHAVIOUR
//  Reset (rst=0, async): txd=1, tbr=1, rda=0, databus=Z, divisor=DEFAULT_DIVISOR, FSMs idle.
//  Bus writes (iocs=1, iorw=0) take effect at the clk posedge, one cycle each:
//   - 00: if tbr=1, load TX shift reg; tbr=0 next cycle; frame starts. If tbr=0, write ignored,
//     so a write held across a whole frame sends exactly one byte.
//   - 10 / 11: update divisor[7:0] / [15:8]; baud counter reloads immediately.
//  Bus reads (iocs=1, iorw=1) drive databus combinationally:
//   - 00: RX buffer.
//   - 01: {6'b0, tbr, rda}.
//   - 10 / 11: write-only; databus stays Z.
//   - Read of 00 clears rda at the next posedge.
//  databus is Z whenever iocs=0 or iorw=0.
//  Baud generator:
//   - Down-counter reloaded with the divisor; one-cycle tick when it reaches 0.
//   - Tick period = divisor+1 clocks; divisor 0 gives a tick every clock.
//   - Bit time = 16 ticks.
//  TX FSM IDLE->START->DATA(8, LSB first)->STOP->IDLE, each state 16 ticks.
//   - Start bit is 0, stop bit is 1.
//   - tbr returns to 1 at the end of the stop bit; back-to-back writes are allowed after that.
//  RX path:
//   - rxd passes through a 2-flop synchronizer.
//   - IDLE: a 0 detected on a tick enters START.
//   - START: re-check the line at 8 ticks (mid-bit); if 1, false start, return to IDLE.
//   - DATA: sample every 16 ticks thereafter, 8 bits, LSB first.
//   - STOP: sample the stop bit.
//   - Stop=1: RX buffer loaded, rda=1.
//   - Stop=0 (framing error): byte discarded, rda unchanged; wait for the line to go high, then IDLE.
//  Boundary rules:
//   - Overrun (new byte completes while rda=1): buffer overwritten, rda stays 1.
//   - Byte completion coinciding with a read-clear of rda: set wins (rda=1, new data).
//   - TX and RX run fully independently (full duplex).
//   - Divisor write mid-frame: takes effect on the next tick; the frame is not restarted.
//   - Reset mid-frame: txd returns to 1 immediately; any partial RX byte is dropped.
// STRUCTURE
//  spart_pkg: ioaddr constants (ADDR_DATA, ADDR_STATUS, ADDR_DB_LO, ADDR_DB_HI), TX/RX state enums,
//   OVERSAMPLE.
//  Sub-module spart_baud_gen: divisor regs + counter, outputs tick.
//  TX, RX and bus decode stay in spart.
// TESTING
//  1) Reset: txd=1, tbr=1, rda=0, databus=Z; divisor reads back as nothing (Z).
//  2) Program divisor A2/00; write 0x67 on addr 00 -> tbr=0 next cycle.
//     txd sends 0,1,1,1,0,0,1,1,0,1 at 2608 clk/bit.
//     Peer rda=1; peer read of 00 returns 0x67; peer rda=0 next cycle.
//  3) Status read on addr 01 -> databus = {6'b0,tbr,rda}, e.g. 8'h02 idle, 8'h03 after receive.
//  4) Full duplex: A sends 0x23 while B sends 0x99 -> each rda=1 with the correct byte, no corruption.
//  5) Hold a write to 00 with new data while tbr=0 -> ignored; only the first byte is transmitted.
//  6) Async reset mid-frame -> txd=1 and tbr=1 without a clk edge.
//     A rxd glitch shorter than half a bit -> no rda.

Source files
------------

// File: rtl/spart_pkg.sv
// spart_pkg: shared constants and state types for the spart UART.
//   ADDR_*      : ioaddr decode values for the processor bus
//   OVERSAMPLE  : baud ticks per serial bit
//   TICK_LAST   : tick count value that closes one bit period
//   TICK_MID    : tick count value at which the start bit is re-checked
//   tx_state_t / rx_state_t : transmitter and receiver FSM states
package spart_pkg;

    localparam int OVERSAMPLE = 16;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_DB_LO  = 2'b10;
    localparam logic [1:0] ADDR_DB_HI  = 2'b11;

    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: programmable baud tick generator.
// Holds the 16-bit divisor and a down-counter reloaded from it; tick_o is
// high for one clock each time the counter reaches zero, giving a tick
// period of divisor+1 clocks (divisor 0 ticks every clock).
//   clk       in   system clock
//   rst       in   asynchronous reset, active low
//   wr_lo_i   in   write divisor[7:0] from wdata_i
//   wr_hi_i   in   write divisor[15:8] from wdata_i
//   wdata_i   in   divisor write data
//   tick_o    out  one-cycle baud tick
module spart_baud_gen #(
    parameter logic [15:0] DEFAULT_DIVISOR = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_lo_i,
    input  logic       wr_hi_i,
    input  logic [7:0] wdata_i,
    output logic       tick_o
);

    logic [15:0] div_q, div_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        div_d = div_q;
        if (wr_lo_i) div_d[7:0]  = wdata_i;
        if (wr_hi_i) div_d[15:8] = wdata_i;
    end

    assign tick_o = (cnt_q == 16'd0);

    // A divisor write restarts the count from the new value so the change
    // shows up on the very next tick without disturbing any frame in flight.
    always_comb begin
        if (wr_lo_i || wr_hi_i) begin
            cnt_d = div_d;
        end else if (tick_o) begin
            cnt_d = div_q;
        end else begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= DEFAULT_DIVISOR;
            cnt_q <= DEFAULT_DIVISOR;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spart.sv
// spart: 8N1 UART with a small processor bus.
//   clk      in     system clock
//   rst      in     asynchronous reset, active low
//   iocs     in     chip select
//   iorw     in     1 = read (spart drives databus), 0 = write
//   rda      out    receive data available
//   tbr      out    transmit buffer ready
//   ioaddr   in     00 data, 01 status, 10 divisor lo, 11 divisor hi
//   databus  inout  shared 8-bit bus, Z unless a readable register is read
//   txd      out    serial out, idles high
//   rxd      in     serial in, asynchronous
//
// TX states
//   state     | meaning
//   TX_IDLE   | line high, tbr=1, waiting for a data write
//   TX_START  | start bit (0) for 16 ticks
//   TX_DATA   | 8 data bits LSB first, 16 ticks each
//   TX_STOP   | stop bit (1) for 16 ticks, then back to idle
// RX states
//   state        | meaning
//   RX_IDLE      | waiting for a low line on a tick
//   RX_START     | re-checking the start bit at mid-bit
//   RX_DATA      | sampling 8 data bits every 16 ticks
//   RX_STOP      | sampling the stop bit
//   RX_WAIT_HIGH | framing error, waiting for the line to return high
module spart
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIVISOR = 16'h00A2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    output logic       rda,
    output logic       tbr,
    input  logic [1:0] ioaddr,
    inout  wire  [7:0] databus,
    output logic       txd,
    input  logic       rxd
);

    logic tick;
    logic wr_en, rd_en, wr_data, wr_lo, wr_hi, rd_data_clr;
    logic rd_drive;
    logic [7:0] rd_data;

    tx_state_t  tx_state_q, tx_state_d;
    logic [3:0] tx_tcnt_q, tx_tcnt_d;
    logic [2:0] tx_bit_q, tx_bit_d;
    logic [7:0] tx_shift_q, tx_shift_d;

    logic [1:0] rx_sync_q;
    logic       rxd_s;
    rx_state_t  rx_state_q, rx_state_d;
    logic [3:0] rx_tcnt_q, rx_tcnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] rx_buf_q, rx_buf_d;
    logic       rda_q, rda_d;

    // Bus decode
    assign wr_en       = iocs & ~iorw;
    assign rd_en       = iocs & iorw;
    assign wr_data     = wr_en && (ioaddr == ADDR_DATA);
    assign wr_lo       = wr_en && (ioaddr == ADDR_DB_LO);
    assign wr_hi       = wr_en && (ioaddr == ADDR_DB_HI);
    assign rd_data_clr = rd_en && (ioaddr == ADDR_DATA);

    always_comb begin
        rd_drive = 1'b0;
        rd_data  = 8'h00;
        if (rd_en) begin
            case (ioaddr)
                ADDR_DATA: begin
                    rd_drive = 1'b1;
                    rd_data  = rx_buf_q;
                end
                ADDR_STATUS: begin
                    rd_drive = 1'b1;
                    rd_data  = {6'b0, tbr, rda_q};
                end
                default: ;
            endcase
        end
    end

    assign databus = rd_drive ? rd_data : 8'bz;

    spart_baud_gen #(
        .DEFAULT_DIVISOR(DEFAULT_DIVISOR)
    ) u_baud_gen (
        .clk    (clk),
        .rst    (rst),
        .wr_lo_i(wr_lo),
        .wr_hi_i(wr_hi),
        .wdata_i(databus),
        .tick_o (tick)
    );

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_tcnt_q  <= 4'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            rx_sync_q  <= 2'b11;
            rx_state_q <= RX_IDLE;
            rx_tcnt_q  <= 4'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_buf_q   <= 8'h00;
            rda_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tcnt_q  <= tx_tcnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            rx_sync_q  <= {rx_sync_q[0], rxd};
            rx_state_q <= rx_state_d;
            rx_tcnt_q  <= rx_tcnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_buf_q   <= rx_buf_d;
            rda_q      <= rda_d;
        end
    end

    assign rxd_s = rx_sync_q[1];

    // TX next state. The tick counter wraps 15->0 on its own, so each state
    // simply advances when the last tick of its bit arrives.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            TX_IDLE: begin
                tx_tcnt_d = 4'd0;
                if (wr_data) begin
                    tx_shift_d = databus;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == TICK_LAST) begin
                        tx_bit_d   = 3'd0;
                        tx_state_d = TX_DATA;
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == TICK_LAST) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                        if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    tx_tcnt_d = tx_tcnt_q + 4'd1;
                    if (tx_tcnt_q == TICK_LAST) tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // RX next state. A read-clear of rda is applied first so that a byte
    // completing in the same cycle wins and leaves rda set.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tcnt_d  = rx_tcnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_buf_d   = rx_buf_q;
        rda_d      = rda_q;
        if (rd_data_clr) rda_d = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_tcnt_d = 4'd0;
                if (tick && !rxd_s) rx_state_d = RX_START;
            end
            RX_START: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == TICK_MID) begin
                        rx_tcnt_d = 4'd0;
                        rx_bit_d  = 3'd0;
                        rx_state_d = rxd_s ? RX_IDLE : RX_DATA;
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == TICK_LAST) begin
                        rx_shift_d = {rxd_s, rx_shift_q[7:1]};
                        rx_bit_d   = rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (tick) begin
                    rx_tcnt_d = rx_tcnt_q + 4'd1;
                    if (rx_tcnt_q == TICK_LAST) begin
                        if (rxd_s) begin
                            rx_buf_d   = rx_shift_q;
                            rda_d      = 1'b1;
                            rx_state_d = RX_IDLE;
                        end else begin
                            rx_state_d = RX_WAIT_HIGH;
                        end
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rxd_s) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Outputs decoded from state so reset forces txd high with no clock.
    always_comb begin
        txd = 1'b1;
        case (tx_state_q)
            TX_START: txd = 1'b0;
            TX_DATA:  txd = tx_shift_q[0];
            default:  txd = 1'b1;
        endcase
        tbr = (tx_state_q == TX_IDLE);
        rda = rda_q;
    end

endmodule

// File: tb/tb_spart.sv
module tb_spart;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_iocs, a_iorw, b_iocs, b_iorw;
    logic [1:0] a_addr, b_addr;
    logic [7:0] a_drv, b_drv;
    logic       a_drv_en, b_drv_en;
    wire  [7:0] a_db, b_db;
    logic       a_rda, a_tbr, a_txd, b_rda, b_tbr, b_txd;
    logic       glitch_en;
    logic       b_rxd;

    int n_pass  = 0;
    int n_total = 0;

    assign a_db = a_drv_en ? a_drv : 8'hzz;
    assign b_db = b_drv_en ? b_drv : 8'hzz;
    pullup (a_db);
    pullup (b_db);

    assign b_rxd = glitch_en ? 1'b0 : a_txd;

    spart u_a (
        .clk(clk), .rst(rst), .iocs(a_iocs), .iorw(a_iorw), .rda(a_rda), .tbr(a_tbr),
        .ioaddr(a_addr), .databus(a_db), .txd(a_txd), .rxd(b_txd)
    );

    spart u_b (
        .clk(clk), .rst(rst), .iocs(b_iocs), .iorw(b_iorw), .rda(b_rda), .tbr(b_tbr),
        .ioaddr(b_addr), .databus(b_db), .txd(b_txd), .rxd(b_rxd)
    );

    task automatic idle_bus();
        a_iocs = 1'b0; a_iorw = 1'b0; a_addr = 2'b00; a_drv = 8'h00; a_drv_en = 1'b0;
        b_iocs = 1'b0; b_iorw = 1'b0; b_addr = 2'b00; b_drv = 8'h00; b_drv_en = 1'b0;
    endtask

    task automatic bus_write(input bit inst, input logic [1:0] addr, input logic [7:0] data);
        @(negedge clk);
        if (!inst) begin
            a_iocs = 1'b1; a_iorw = 1'b0; a_addr = addr; a_drv = data; a_drv_en = 1'b1;
        end else begin
            b_iocs = 1'b1; b_iorw = 1'b0; b_addr = addr; b_drv = data; b_drv_en = 1'b1;
        end
        @(negedge clk);
        idle_bus();
    endtask

    task automatic bus_read(input bit inst, input logic [1:0] addr, output logic [7:0] data);
        @(negedge clk);
        if (!inst) begin
            a_iocs = 1'b1; a_iorw = 1'b1; a_addr = addr;
        end else begin
            b_iocs = 1'b1; b_iorw = 1'b1; b_addr = addr;
        end
        #1;
        data = inst ? b_db : a_db;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic set_divisor(input logic [7:0] lo, input logic [7:0] hi);
        bus_write(0, 2'b10, lo);
        bus_write(0, 2'b11, hi);
        bus_write(1, 2'b10, lo);
        bus_write(1, 2'b11, hi);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        idle_bus();
        glitch_en = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (a_txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", a_txd); else n_pass++;
        n_total++; if (a_tbr !== 1'b1) $display("FAIL reset_tbr: got %b want 1", a_tbr); else n_pass++;
        n_total++; if (a_rda !== 1'b0) $display("FAIL reset_rda: got %b want 0", a_rda); else n_pass++;
        n_total++; if (a_db !== 8'hFF) $display("FAIL reset_bus_idle: got %h want released", a_db); else n_pass++;
        bus_read(0, 2'b01, d);
        n_total++; if (d !== 8'h02) $display("FAIL reset_status: got %h want 02", d); else n_pass++;
        bus_read(0, 2'b10, d);
        n_total++; if (d !== 8'hFF) $display("FAIL divlo_read_z: got %h want released", d); else n_pass++;
        bus_read(0, 2'b11, d);
        n_total++; if (d !== 8'hFF) $display("FAIL divhi_read_z: got %h want released", d); else n_pass++;
    endtask

    // 0x67 at 2608 clocks per bit, sampled mid-bit from the start edge.
    task automatic test_basic_tx();
        logic [9:0] frame;
        int cyc;
        frame = {1'b1, 8'h67, 1'b0};
        set_divisor(8'hA2, 8'h00);
        bus_write(0, 2'b00, 8'h67);
        n_total++; if (a_tbr !== 1'b0) $display("FAIL tx_tbr_low: got %b want 0", a_tbr); else n_pass++;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) repeat (1303) @(negedge clk);
            else        repeat (2608) @(negedge clk);
            n_total++;
            if (a_txd !== frame[k]) $display("FAIL tx_bit%0d: got %b want %b", k, a_txd, frame[k]);
            else n_pass++;
            if (k == 4) begin
                n_total++; if (b_rda !== 1'b0) $display("FAIL rx_rda_early: got %b want 0", b_rda); else n_pass++;
            end
        end
        cyc = 0;
        while (b_rda !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
        n_total++; if (b_rda !== 1'b1) $display("FAIL rx_rda_set: got %b want 1", b_rda); else n_pass++;
        cyc = 0;
        while (a_tbr !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
        n_total++; if (a_tbr !== 1'b1) $display("FAIL tx_tbr_return: got %b want 1", a_tbr); else n_pass++;
    endtask

    task automatic test_status();
        logic [7:0] d;
        bus_read(1, 2'b01, d);
        n_total++; if (d !== 8'h03) $display("FAIL status_after_rx: got %h want 03", d); else n_pass++;
        bus_read(1, 2'b00, d);
        n_total++; if (d !== 8'h67) $display("FAIL rx_data_67: got %h want 67", d); else n_pass++;
        n_total++; if (b_rda !== 1'b0) $display("FAIL rda_read_clear: got %b want 0", b_rda); else n_pass++;
        bus_read(1, 2'b01, d);
        n_total++; if (d !== 8'h02) $display("FAIL status_after_clear: got %h want 02", d); else n_pass++;
        bus_read(0, 2'b01, d);
        n_total++; if (d !== 8'h02) $display("FAIL status_tx_idle: got %h want 02", d); else n_pass++;
    endtask

    task automatic test_full_duplex();
        logic [7:0] d;
        int cyc;
        bus_write(0, 2'b00, 8'h23);
        bus_write(1, 2'b00, 8'h99);
        cyc = 0;
        while ((a_rda !== 1'b1 || b_rda !== 1'b1) && cyc < 2000) begin @(negedge clk); cyc++; end
        n_total++; if (a_rda !== 1'b1) $display("FAIL duplex_a_rda: got %b want 1", a_rda); else n_pass++;
        n_total++; if (b_rda !== 1'b1) $display("FAIL duplex_b_rda: got %b want 1", b_rda); else n_pass++;
        bus_read(0, 2'b00, d);
        n_total++; if (d !== 8'h99) $display("FAIL duplex_a_data: got %h want 99", d); else n_pass++;
        bus_read(1, 2'b00, d);
        n_total++; if (d !== 8'h23) $display("FAIL duplex_b_data: got %h want 23", d); else n_pass++;
        cyc = 0;
        while ((a_tbr !== 1'b1 || b_tbr !== 1'b1) && cyc < 2000) begin @(negedge clk); cyc++; end
    endtask

    task automatic test_hold_write();
        logic [7:0] d;
        int cyc;
        @(negedge clk);
        a_iocs = 1'b1; a_iorw = 1'b0; a_addr = 2'b00; a_drv = 8'h5A; a_drv_en = 1'b1;
        @(negedge clk);
        a_drv = 8'hC3;
        n_total++; if (a_tbr !== 1'b0) $display("FAIL hold_tbr_low: got %b want 0", a_tbr); else n_pass++;
        repeat (590) @(negedge clk);
        n_total++; if (a_tbr !== 1'b0) $display("FAIL hold_tbr_still_low: got %b want 0", a_tbr); else n_pass++;
        idle_bus();
        cyc = 0;
        while (b_rda !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        n_total++; if (b_rda !== 1'b1) $display("FAIL hold_rx_rda: got %b want 1", b_rda); else n_pass++;
        bus_read(1, 2'b00, d);
        n_total++; if (d !== 8'h5A) $display("FAIL hold_rx_data: got %h want 5A", d); else n_pass++;
        repeat (800) @(negedge clk);
        n_total++; if (b_rda !== 1'b0) $display("FAIL hold_no_second_byte: got %b want 0", b_rda); else n_pass++;
        n_total++; if (a_tbr !== 1'b1) $display("FAIL hold_tbr_idle: got %b want 1", a_tbr); else n_pass++;
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        int cyc;
        bus_write(0, 2'b00, 8'h11);
        cyc = 0;
        while (a_tbr !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        n_total++; if (b_rda !== 1'b1) $display("FAIL overrun_first_rda: got %b want 1", b_rda); else n_pass++;
        bus_write(0, 2'b00, 8'h22);
        cyc = 0;
        while (a_tbr !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        n_total++; if (b_rda !== 1'b1) $display("FAIL overrun_rda_held: got %b want 1", b_rda); else n_pass++;
        bus_read(1, 2'b00, d);
        n_total++; if (d !== 8'h22) $display("FAIL overrun_data: got %h want 22", d); else n_pass++;
    endtask

    task automatic test_reset_midframe();
        bus_write(0, 2'b00, 8'h00);
        repeat (100) @(negedge clk);
        n_total++; if (a_txd !== 1'b0) $display("FAIL midframe_txd_low: got %b want 0", a_txd); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++; if (a_txd !== 1'b1) $display("FAIL async_reset_txd: got %b want 1", a_txd); else n_pass++;
        n_total++; if (a_tbr !== 1'b1) $display("FAIL async_reset_tbr: got %b want 1", a_tbr); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        set_divisor(8'h03, 8'h00);
        repeat (800) @(negedge clk);
        n_total++; if (b_rda !== 1'b0) $display("FAIL partial_rx_dropped: got %b want 0", b_rda); else n_pass++;
    endtask

    task automatic test_glitch();
        logic [7:0] d;
        int cyc;
        @(negedge clk);
        glitch_en = 1'b1;
        repeat (20) @(negedge clk);
        glitch_en = 1'b0;
        repeat (300) @(negedge clk);
        n_total++; if (b_rda !== 1'b0) $display("FAIL glitch_no_rda: got %b want 0", b_rda); else n_pass++;
        bus_write(0, 2'b00, 8'hA5);
        cyc = 0;
        while (b_rda !== 1'b1 && cyc < 1000) begin @(negedge clk); cyc++; end
        n_total++; if (b_rda !== 1'b1) $display("FAIL after_glitch_rda: got %b want 1", b_rda); else n_pass++;
        bus_read(1, 2'b00, d);
        n_total++; if (d !== 8'hA5) $display("FAIL after_glitch_data: got %h want A5", d); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_tx();
        test_status();
        set_divisor(8'h03, 8'h00);
        test_full_duplex();
        test_hold_write();
        test_overrun();
        test_reset_midframe();
        test_glitch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
